// File: rtl/nios_core_key_in.sv
`default_nettype none
// ============================================================================
// Module   : nios_core_key_in
// Avalon-MM key/switch input port with sticky edge capture and level IRQ.
// Optional debounce filter compiled in by NIOS_CORE_KEY_IN_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
module nios_core_key_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE            = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused;

  assign w_unused = ^{writedata, 16'(DEBOUNCE_CYCLES)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

`ifdef NIOS_CORE_KEY_IN_DEBOUNCE_EN
  localparam logic [15:0] C_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_f;
  logic [15:0]      r_cnt [WIDTH];

  // f only follows s2 after it has disagreed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_f[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == C_CNT_LAST) begin
          r_cnt[i] <= '0;
          r_f[i]   <= ~r_f[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign w_f = r_f;
`else
  assign w_f = r_s2;
`endif

  generate
    if (EDGE == 0) begin : g_edge_rise
      assign w_edge = w_f & ~r_p;
    end else if (EDGE == 1) begin : g_edge_fall
      assign w_edge = ~w_f & r_p;
    end else begin : g_edge_any
      assign w_edge = w_f ^ r_p;
    end
  endgenerate

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // a new edge in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p       <= '0;
      r_cap     <= '0;
      r_irqmask <= '0;
    end else begin
      r_p   <= w_f;
      r_cap <= (r_cap & ~w_clr) | w_edge;
      if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(r_cap & r_irqmask);

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata[WIDTH-1:0] = w_f;
        2'd2:    readdata[WIDTH-1:0] = r_irqmask;
        2'd3:    readdata[WIDTH-1:0] = r_cap;
        default: readdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_core_key_in.sv
`default_nettype none
// Testbench for nios_core_key_in: register table, directed edge/IRQ cases,
// randomized check against a pin-history model, debounce and reset cases.
module tb_nios_core_key_in;
  localparam int WIDTH = 4;
`ifdef NIOS_CORE_KEY_IN_DEBOUNCE_EN
  localparam int DB  = 8;
  localparam int LAT = 8;
`else
  localparam int DB  = 50000;
  localparam int LAT = 0;
`endif
  localparam int NR = 200;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [WIDTH-1:0] in_port = '1;
  logic [31:0]      readdata;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nios_core_key_in #(.WIDTH(WIDTH), .EDGE(1), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    idle();
  endtask

  initial begin
    logic [31:0]      d;
    logic [WIDTH-1:0] hist [NR+4];
    logic [WIDTH-1:0] m_cap, m_mask, m_f, p_clr, p_md, nin;
    logic             p_mw, cs, wn;
    logic [1:0]       ad;
    logic [31:0]      wd, exp_rd;

    // register map with pins steady at 4'hF (f = F, cap = 0)
    tbl[0]  = '{1'b0, 1'b1, 2'd0, 32'h0,        32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'd0, 32'h0,        32'hF, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFF5, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h5, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 2'd3, 32'h0,        32'h0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'hF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h5, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'd2, 32'hF,        32'h0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};

    // reset state
    tick(3);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rd(2'd0, d); check("reset_data", d, 32'h0);
    rd(2'd3, d); check("reset_cap", d, 32'h0);
    reset_n = 1'b1;
    tick(6 + LAT);
    wr(2'd3, 32'hF);
    tick();

    for (int i = 0; i < 13; i++) begin
      chipselect = tbl[i].cs;
      write_n    = tbl[i].wn;
      address    = tbl[i].addr;
      writedata  = tbl[i].wd;
      #1;
      check($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
      tick();
      idle();
    end

`ifndef NIOS_CORE_KEY_IN_DEBOUNCE_EN
    // falling edge on bit0: data after 2 cycles, capture after 3
    in_port = 4'hE;
    tick(2);
    rd(2'd0, d); check("fall_data", d, 32'hE);
    rd(2'd3, d); check("fall_cap_early", d, 32'h0);
    tick();
    rd(2'd3, d); check("fall_cap", d, 32'h1);
    check("fall_irq_masked", {31'b0, irq}, 32'h0);

    wr(2'd2, 32'h1);
    check("unmask_irq", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    check("clear_irq", {31'b0, irq}, 32'h0);
    rd(2'd3, d); check("clear_cap", d, 32'h0);

    // clear coinciding with a new edge: set wins
    in_port = 4'hF;
    tick(4);
    rd(2'd3, d); check("rise_no_cap", d, 32'h0);
    in_port = 4'hE;
    tick(2);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h1;
    tick();
    idle();
    rd(2'd3, d); check("setwins_cap", d, 32'h1);
    check("setwins_irq", {31'b0, irq}, 32'h1);

    // randomized traffic against pin-history model
    m_mask = 4'($urandom);
    wr(2'd2, {28'b0, m_mask});
    nin = 4'($urandom);
    in_port = nin;
    tick(4);
    wr(2'd3, 32'hF);
    for (int k = 0; k < 4; k++) hist[k] = nin;
    m_cap = '0; p_clr = '0; p_mw = 1'b0; p_md = '0;
    for (int m = 0; m < NR; m++) begin
      // state after edge m: f is the pin value from two cycles back
      m_cap = (m_cap & ~p_clr) | (~hist[m+1] & hist[m]);
      if (p_mw) m_mask = p_md;
      m_f = hist[m+2];
      nin = 4'($urandom);
      hist[m+4] = nin;
      in_port = nin;
      cs = ($urandom_range(0, 3) != 0);
      wn = 1'($urandom_range(0, 1));
      ad = 2'($urandom_range(0, 3));
      wd = $urandom & $urandom;
      chipselect = cs; write_n = wn; address = ad; writedata = wd;
      #1;
      exp_rd = '0;
      if (cs) begin
        if (ad == 2'd0) exp_rd = {28'b0, m_f};
        if (ad == 2'd2) exp_rd = {28'b0, m_mask};
        if (ad == 2'd3) exp_rd = {28'b0, m_cap};
      end
      check($sformatf("rand%0d_rd", m), readdata, exp_rd);
      check($sformatf("rand%0d_irq", m), {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
      p_clr = (cs && !wn && ad == 2'd3) ? wd[3:0] : 4'h0;
      p_mw  = cs && !wn && ad == 2'd2;
      p_md  = wd[3:0];
      tick();
    end
    idle();
`else
    // bit1 bounces every 3 cycles for 30 cycles, then holds low
    for (int t = 0; t <= 45; t++) begin
      rd(2'd0, d); check($sformatf("bounce%0d_f", t), d, (t >= 40) ? 32'hD : 32'hF);
      rd(2'd3, d); check($sformatf("bounce%0d_cap", t), d, (t >= 41) ? 32'h2 : 32'h0);
      if (t < 30) in_port = (((t / 3) % 2) == 0) ? 4'hD : 4'hF;
      else        in_port = 4'hD;
      tick();
    end
`endif

    // reset in the middle of a pending filter/pipeline change
    in_port = 4'hF;
    tick(4 + LAT);
    wr(2'd2, 32'hF);
    wr(2'd3, 32'hF);
    in_port = 4'hA;
    tick(3 + LAT);
    rd(2'd3, d); check("pre_rst_cap", d, 32'h5);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    in_port = 4'h0;
    tick(2 + LAT / 2);
    reset_n = 1'b0;
    #1;
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rd_unsel", readdata, 32'h0);
    rd(2'd3, d); check("rst_cap", d, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(20 + 2 * LAT);
    rd(2'd0, d); check("post_rst_data", d, 32'h0);
    rd(2'd2, d); check("post_rst_mask", d, 32'h0);
    rd(2'd3, d); check("post_rst_cap", d, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
